// File: rtl/wb_select_pipe_pkg.sv
// Shared definitions for the writeback-select stage: load-mode encoding,
// the hard-wired zero register and the output-stage occupancy states.
package wb_pkg;

   typedef enum logic [2:0] {
      WORD = 3'd0,
      LB   = 3'd1,
      LBU  = 3'd2,
      LH   = 3'd3,
      LHU  = 3'd4
   } ld_mode_t;

   localparam int unsigned ZERO_REG = 0;

   // Occupancy of the main register plus skid entry
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_MAIN  = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   function automatic logic is_half_mode(input logic [2:0] mode);
      return (mode == 3'(LH)) || (mode == 3'(LHU));
   endfunction

endpackage

// File: rtl/wb_select_pipe_if.sv
// Request/response bundle between MEM, the writeback-select stage and the
// register-file write port.
interface wb_select_pipe_if #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 4,
   parameter int AW    = 5
);
   localparam int SELW = $clog2(NSRC);

   logic                    in_valid;
   logic                    in_ready;
   logic [NSRC*WIDTH-1:0]   in_src;
   logic [SELW-1:0]         in_sel;
   logic [2:0]              in_ldmode;
   logic [1:0]              in_addr_lo;
   logic [AW-1:0]           in_rd;
   logic                    in_we;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_wd;
   logic [AW-1:0]           out_rd;
   logic                    out_we;
   logic                    out_err;

   modport slave (
      input  in_valid, in_src, in_sel, in_ldmode, in_addr_lo, in_rd, in_we, out_ready,
      output in_ready, out_valid, out_wd, out_rd, out_we, out_err
   );

   modport master (
      output in_valid, in_src, in_sel, in_ldmode, in_addr_lo, in_rd, in_we, out_ready,
      input  in_ready, out_valid, out_wd, out_rd, out_we, out_err
   );

endinterface

// File: rtl/wb_load_ext.sv
// Combinational sub-word load extraction with sign/zero extension. Misaligned
// halfwords still return the lane picked by addr_lo[1] but raise err.
module wb_load_ext
   import wb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] word,
   input  logic [2:0]       ldmode,
   input  logic [1:0]       addr_lo,
   output logic [WIDTH-1:0] data,
   output logic             err
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign byte_s = word[{addr_lo, 3'b000} +: 8];
   assign half_s = word[{addr_lo[1], 4'b0000} +: 16];

   // Lane extraction and extension per load mode
   always_comb begin
      data = '0;
      err  = 1'b0;
      case (ldmode)
         3'(WORD): data = word;
         3'(LB):   data = {{(WIDTH-8){byte_s[7]}}, byte_s};
         3'(LBU):  data = {{(WIDTH-8){1'b0}}, byte_s};
         3'(LH):   data = {{(WIDTH-16){half_s[15]}}, half_s};
         3'(LHU):  data = {{(WIDTH-16){1'b0}}, half_s};
         default: begin
            data = '0;
            err  = 1'b1;
         end
      endcase
      if (is_half_mode(ldmode) && addr_lo[0]) begin
         err = 1'b1;
      end else begin
         err = err;
      end
   end

endmodule

// File: rtl/wb_select_pipe.sv
// Writeback-select stage: picks one of NSRC results, extends data-memory loads,
// qualifies the write-enable and presents it through a main register + skid entry.
module wb_select_pipe
   import wb_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NSRC   = 4,
   parameter int DM_IDX = 1,
   parameter int AW     = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   wb_select_pipe_if.slave  bus
);

   localparam int SELW = $clog2(NSRC);

   typedef struct packed {
      logic [WIDTH-1:0] wd;
      logic [AW-1:0]    rd;
      logic             we;
      logic             err;
   } res_t;

   logic [WIDTH-1:0] sel_src_s;
   logic [WIDTH-1:0] dm_word_s;
   logic [WIDTH-1:0] ext_data_s;
   logic             ext_err_s;
   logic             sel_ok_s;
   logic             is_dm_s;
   logic             accept_s;
   res_t             new_s;
   res_t             main_r, main_d;
   res_t             skid_r, skid_d;
   occ_t             state_r, state_d;
   logic             in_ready_r;

   assign dm_word_s = bus.in_src[DM_IDX*WIDTH +: WIDTH];
   assign sel_ok_s  = (32'(bus.in_sel) < 32'(NSRC));
   assign is_dm_s   = (32'(bus.in_sel) == 32'(DM_IDX));
   assign accept_s  = bus.in_valid && in_ready_r;

   // One-hot AND-OR source mux; out-of-range selects yield zero
   always_comb begin
      sel_src_s = '0;
      for (int k = 0; k < NSRC; k++) begin
         sel_src_s = sel_src_s
                   | (bus.in_src[k*WIDTH +: WIDTH] & {WIDTH{32'(bus.in_sel) == 32'(k)}});
      end
   end

   wb_load_ext #(.WIDTH(WIDTH)) u_load_ext (
      .word    (dm_word_s),
      .ldmode  (bus.in_ldmode),
      .addr_lo (bus.in_addr_lo),
      .data    (ext_data_s),
      .err     (ext_err_s)
   );

   // Result formation and write-enable qualification for the offered request
   always_comb begin
      new_s = '0;
      if (!sel_ok_s) begin
         new_s.wd  = '0;
         new_s.err = 1'b1;
      end else if (is_dm_s) begin
         new_s.wd  = ext_data_s;
         new_s.err = ext_err_s;
      end else begin
         new_s.wd  = sel_src_s;
         new_s.err = 1'b0;
      end
      new_s.rd = bus.in_rd;
      new_s.we = bus.in_we && !new_s.err && (bus.in_rd != AW'(ZERO_REG));
   end

   // Occupancy next-state and entry updates; accept is impossible while full
   always_comb begin
      state_d = state_r;
      main_d  = main_r;
      skid_d  = skid_r;
      case (state_r)
         OCC_EMPTY: begin
            if (accept_s) begin
               main_d  = new_s;
               state_d = OCC_MAIN;
            end else begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_MAIN: begin
            if (bus.out_ready) begin
               if (accept_s) begin
                  main_d  = new_s;
                  state_d = OCC_MAIN;
               end else begin
                  state_d = OCC_EMPTY;
               end
            end else if (accept_s) begin
               skid_d  = new_s;
               state_d = OCC_FULL;
            end else begin
               state_d = OCC_MAIN;
            end
         end
         OCC_FULL: begin
            if (bus.out_ready) begin
               main_d  = skid_r;
               state_d = OCC_MAIN;
            end else begin
               state_d = OCC_FULL;
            end
         end
         default: begin
            state_d = OCC_EMPTY;
         end
      endcase
   end

   // State and data registers; reset flushes both entries at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= OCC_EMPTY;
         main_r     <= '0;
         skid_r     <= '0;
         in_ready_r <= 1'b0;
      end else begin
         state_r    <= state_d;
         main_r     <= main_d;
         skid_r     <= skid_d;
         in_ready_r <= (state_d != OCC_FULL);
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = (state_r != OCC_EMPTY);
   assign bus.out_wd    = main_r.wd;
   assign bus.out_rd    = main_r.rd;
   assign bus.out_we    = main_r.we;
   assign bus.out_err   = main_r.err;

endmodule
